m_ext_issue: RTL

M_EXT_ISSUE -- requirements
Module: m_ext_issue

---
 rtl/m_ext_pkg.sv | 26 ++
 rtl/m_ext_special.sv | 57 +++++
 rtl/m_ext_issue.sv | 108 ++++++++++
 3 files changed

// File: rtl/m_ext_pkg.sv
// Shared types and constants for the M-extension issue logic.
// Imported by the issue controller and its special-case decoder.
package m_ext_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mext_state_t;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mext_funct3_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/m_ext_special.sv
// Detects divide cases whose result is fixed by the ISA
// (divide by zero, signed overflow) so no unit op is needed.
module m_ext_special
  import m_ext_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic div_zero;
  logic ovf;

  assign div_zero = (b == '0);
  assign ovf      = (a == INT_MIN) && (b == ALL_ONES);

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    unique case (mext_funct3_t'(funct3))
      DIV: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = ALL_ONES;
        end else if (ovf) begin
          is_special     = 1'b1;
          special_result = INT_MIN;
        end
      end
      DIVU: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = ALL_ONES;
        end
      end
      REM: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = a;
        end else if (ovf) begin
          is_special     = 1'b1;
          special_result = '0;
        end
      end
      REMU: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = a;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_ext_issue.sv
// EX-stage issue controller for a multi-cycle M-extension unit:
// latches operands, pulses load, stalls the pipe, returns result.
module m_ext_issue
  import m_ext_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        flush,
  input  logic [31:0] unit_out,
  input  logic        unit_resp,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic [2:0]  unit_funct3,
  output logic        unit_load,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid
);

  mext_state_t state, state_n;

  logic        is_special;
  logic [31:0] special_result;
  logic        issue;
  logic        issue_special;
  logic        capture;
  logic        resp_ok;

  m_ext_special u_special (
    .funct3         (funct3),
    .a              (rs1_val),
    .b              (rs2_val),
    .is_special     (is_special),
    .special_result (special_result)
  );

  // a resp seen alongside load belongs to the previous op
  assign resp_ok = unit_resp & ~unit_load;

  always_comb begin
    state_n       = state;
    issue         = 1'b0;
    issue_special = 1'b0;
    capture       = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_in && !flush) begin
          if (is_special) begin
            issue_special = 1'b1;
            state_n       = DONE;
          end else begin
            issue   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_n = resp_ok ? IDLE : DRAIN;
        end else if (resp_ok) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      DRAIN: begin
        if (unit_resp) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      unit_a      <= '0;
      unit_b      <= '0;
      unit_funct3 <= '0;
      unit_load   <= 1'b0;
      result      <= '0;
    end else begin
      state     <= state_n;
      unit_load <= issue;
      if (issue) begin
        unit_a      <= rs1_val;
        unit_b      <= rs2_val;
        unit_funct3 <= funct3;
      end
      if (issue_special) begin
        result <= special_result;
      end else if (capture) begin
        result <= unit_out;
      end
    end
  end

  assign result_valid = (state == DONE) & ~flush;

  // in DRAIN the pipe waits even under flush: the unit is still busy
  assign stall = ~rst & valid_in &
                 ((state == DRAIN) |
                  (~flush & (state != DONE)));

endmodule
